// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: latches two endpoints, then emits one pixel per
// clock with a write strobe until the end point has been presented.
module line_rasterizer (
    input  logic       clock_in,
    input  logic       reset_n_in,
    input  logic       enable_in,
    input  logic [9:0] x0_in,
    input  logic [8:0] y0_in,
    input  logic [9:0] x1_in,
    input  logic [8:0] y1_in,
    output logic [9:0] horizontal_out,
    output logic [8:0] vertical_out,
    output logic       write_enable_out,
    output logic       ready_out
);

    typedef enum logic [1:0] {StIdle, StSetup, StDraw, StDone} state_t;

    state_t             r_state;
    logic        [9:0]  r_x0;
    logic        [8:0]  r_y0;
    logic        [9:0]  r_x1;
    logic        [8:0]  r_y1;
    logic        [9:0]  r_cx;
    logic        [8:0]  r_cy;
    logic signed [11:0] r_dx;
    logic signed [11:0] r_dy;
    logic signed [11:0] r_err;
    logic               r_sx;   // 1: step +1, 0: step -1
    logic               r_sy;
    logic        [9:0]  r_hor;
    logic        [8:0]  r_ver;
    logic               r_we;
    logic               r_ready;

    logic        [9:0]  w_abs_x;
    logic        [8:0]  w_abs_y;
    logic signed [11:0] w_dx_init;
    logic signed [11:0] w_dy_init;
    logic signed [12:0] w_e2;
    logic               w_step_x;
    logic               w_step_y;
    logic               w_at_end;
    logic signed [11:0] w_err_next;

    assign w_abs_x   = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_abs_y   = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    assign w_dx_init = $signed({2'b00, w_abs_x});
    assign w_dy_init = 12'sd0 - $signed({3'b000, w_abs_y});

    // Both step decisions use the same pre-update error term.
    assign w_e2      = $signed({r_err, 1'b0});
    assign w_step_x  = (w_e2 >= $signed({r_dy[11], r_dy}));
    assign w_step_y  = (w_e2 <= $signed({r_dx[11], r_dx}));
    assign w_at_end  = (r_cx == r_x1) && (r_cy == r_y1);

    // Error term after this cycle's x and/or y step.
    always_comb begin
        w_err_next = r_err;
        if (w_step_x) w_err_next = w_err_next + r_dy;
        if (w_step_y) w_err_next = w_err_next + r_dx;
    end

    // Control FSM with registered pixel, strobe and ready outputs.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= StIdle;
            r_x0    <= '0;
            r_y0    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_hor   <= '0;
            r_ver   <= '0;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_we    <= 1'b0;
                    r_ready <= 1'b1;
                    if (enable_in) begin
                        r_x0    <= x0_in;
                        r_y0    <= y0_in;
                        r_x1    <= x1_in;
                        r_y1    <= y1_in;
                        r_ready <= 1'b0;
                        r_state <= StSetup;
                    end
                end
                StSetup: begin
                    r_dx    <= w_dx_init;
                    r_dy    <= w_dy_init;
                    r_err   <= w_dx_init + w_dy_init;
                    r_sx    <= (r_x0 < r_x1);
                    r_sy    <= (r_y0 < r_y1);
                    r_cx    <= r_x0;
                    r_cy    <= r_y0;
                    r_state <= StDraw;
                end
                StDraw: begin
                    r_hor <= r_cx;
                    r_ver <= r_cy;
                    r_we  <= 1'b1;
                    if (w_at_end) begin
                        r_state <= StDone;
                    end else begin
                        r_err <= w_err_next;
                        if (w_step_x) r_cx <= r_sx ? (r_cx + 10'd1) : (r_cx - 10'd1);
                        if (w_step_y) r_cy <= r_sy ? (r_cy + 9'd1) : (r_cy - 9'd1);
                    end
                end
                StDone: begin
                    // Hold the last pixel; a redraw needs enable to drop first.
                    r_we    <= 1'b0;
                    r_ready <= 1'b1;
                    if (!enable_in) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign horizontal_out   = r_hor;
    assign vertical_out     = r_ver;
    assign write_enable_out = r_we;
    assign ready_out        = r_ready;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed self-checking bench for line_rasterizer.
module tb_line_rasterizer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [9:0] hor;
    logic [8:0] ver;
    logic       we;
    logic       ready;

    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [31:0] obs_q[$];
    int          obs_cyc[$];
    logic [31:0] exp_q[$];

    line_rasterizer u_dut (
        .clock_in         (clk),
        .reset_n_in       (rst_n),
        .enable_in        (en),
        .x0_in            (x0),
        .y0_in            (y0),
        .x1_in            (x1),
        .y1_in            (y1),
        .horizontal_out   (hor),
        .vertical_out     (ver),
        .write_enable_out (we),
        .ready_out        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every strobed pixel with the edge count it followed.
    always @(negedge clk) begin
        if (we) begin
            obs_q.push_back({13'd0, hor, ver});
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix(input int x, input int y);
        logic [9:0] px;
        logic [8:0] py;
        px = x[9:0];
        py = y[8:0];
        return {13'd0, px, py};
    endfunction

    // Reference Bresenham used for the long steep line.
    task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = (ay1 >= ay0) ? ay0 - ay1 : ay1 - ay0;
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) begin
            exp_q.push_back(pix(x, y));
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Draw one line and compare it against exp_q plus the handshake timing.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input string tag);
        int t_en, t_rdy, n_seen, last;
        bit seen;
        @(negedge clk);
        obs_q.delete();
        obs_cyc.delete();
        x0 = ax0[9:0];
        y0 = ay0[8:0];
        x1 = ax1[9:0];
        y1 = ay1[8:0];
        en = 1'b1;
        @(posedge clk);
        #1;
        t_en = cyc;
        check_eq({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
        seen  = 1'b0;
        t_rdy = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                seen  = 1'b1;
                t_rdy = cyc;
            end
        end
        check_eq({tag, "_finished"}, {31'd0, seen}, 32'd1);
        check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_pix%0d", tag, i), obs_q[i], exp_q[i]);
        if (obs_q.size() > 0) begin
            last = obs_q.size() - 1;
            check_eq({tag, "_first_lat"}, obs_cyc[0] - t_en, 32'd2);
            check_eq({tag, "_consec"}, obs_cyc[last] - obs_cyc[0], last);
            check_eq({tag, "_ready_rise"}, t_rdy - obs_cyc[last], 32'd1);
        end
        check_eq({tag, "_hold_xy"}, {13'd0, hor, ver}, pix(ax1, ay1));
        check_eq({tag, "_we_low"}, {31'd0, we}, 32'd0);
        // Enable still high in DONE: no redraw.
        n_seen = obs_q.size();
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_no_redraw"}, obs_q.size(), n_seen);
        check_eq({tag, "_ready_done"}, {31'd0, ready}, 32'd1);
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_ready_idle"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int viol, n_hold;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #23;
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_we", {31'd0, we}, 32'd0);
        check_eq("rst_xy", {13'd0, hor, ver}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Diagonal down-left: every step is diagonal.
        exp_q.delete();
        for (int i = 0; i <= 10; i++) exp_q.push_back(pix(10 - i, 10 - i));
        run_line(10, 10, 0, 0, "diag");

        exp_q.delete();
        for (int i = 0; i <= 7; i++) exp_q.push_back(pix(i, 5));
        run_line(0, 5, 7, 5, "horiz");

        exp_q.delete();
        for (int i = 0; i <= 4; i++) exp_q.push_back(pix(3, i));
        run_line(3, 0, 3, 4, "vert");

        // Shallow line, worked by hand: err 3,1,4,2,5,3.
        exp_q.delete();
        exp_q.push_back(pix(0, 0));
        exp_q.push_back(pix(1, 0));
        exp_q.push_back(pix(2, 1));
        exp_q.push_back(pix(3, 1));
        exp_q.push_back(pix(4, 2));
        exp_q.push_back(pix(5, 2));
        run_line(0, 0, 5, 2, "shallow");

        // Steep negative line at the corner of the coordinate space.
        model_line(1023, 511, 1020, 0);
        check_eq("steep_model_len", exp_q.size(), 32'd512);
        run_line(1023, 511, 1020, 0, "steep");
        viol = 0;
        for (int i = 1; i < obs_q.size(); i++) begin
            if (obs_q[i][8:0] != obs_q[i-1][8:0] - 9'd1) viol++;
            if (obs_q[i][18:9] > obs_q[i-1][18:9]) viol++;
        end
        check_eq("steep_monotonic", viol, 32'd0);

        exp_q.delete();
        exp_q.push_back(pix(4, 4));
        run_line(4, 4, 4, 4, "point");

        // Reset in the middle of a line.
        @(negedge clk);
        obs_q.delete();
        obs_cyc.delete();
        x0 = 10'd0; y0 = 9'd0; x1 = 10'd100; y1 = 9'd50;
        en = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        check_eq("mid_strobing", {31'd0, we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'd0, ready}, 32'd1);
        check_eq("mid_rst_we", {31'd0, we}, 32'd0);
        check_eq("mid_rst_xy", {13'd0, hor, ver}, 32'd0);
        en = 1'b0;
        n_hold = obs_q.size();
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_rst_silent", obs_q.size(), n_hold);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh line after reset, worked by hand: err 2,4,2,4,2.
        exp_q.delete();
        exp_q.push_back(pix(2, 3));
        exp_q.push_back(pix(3, 2));
        exp_q.push_back(pix(4, 2));
        exp_q.push_back(pix(5, 1));
        exp_q.push_back(pix(6, 1));
        run_line(2, 3, 6, 1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
- Bresenham line rasterizer for the graphics pipeline.
- Takes two endpoints in a 10-bit x / 9-bit y pixel space.
- Emits one pixel coordinate per clock, with a write strobe, for the frame-buffer writer downstream.
- Handles all octants, including horizontal, vertical and single-point lines; no clipping.

Parameters:
- none (widths fixed: x 10 bits, y 9 bits)

Ports:
- clock_in  input  1  system clock, all logic on rising edge
- reset_n_in  input  1  asynchronous active-low reset
- enable_in  input  1  level request to draw the line given on x0/y0/x1/y1
- x0_in  input  10  start x
- y0_in  input  9  start y
- x1_in  input  10  end x
- y1_in  input  9  end y
- horizontal_out  output  10  current pixel x
- vertical_out  output  9  current pixel y
- write_enable_out  output  1  high for exactly one cycle per valid pixel
- ready_out  output  1  high when idle/finished; low while a line is in progress

Behaviour:
- Reset (asynchronous, reset_n_in low) puts all outputs in this state:
  - state IDLE
  - horizontal_out = 0, vertical_out = 0
  - write_enable_out = 0, ready_out = 1
  - internal registers cleared
- Reset mid-line aborts immediately; no further pixels are emitted.
- States: IDLE, SETUP, DRAW, DONE.
- IDLE: ready_out = 1. On a clock edge with enable_in = 1:
  - latch x0/y0/x1/y1
  - ready_out goes 0
  - go to SETUP
- SETUP (1 cycle) computes:
  - dx = |x1 - x0| and sx = +1 if x0 < x1 else -1
  - dy = -|y1 - y0| and sy = +1 if y0 < y1 else -1
  - err = dx + dy
  - current point = (x0, y0)
  - then go to DRAW
- Arithmetic widths:
  - err: signed 12 bits
  - e2 = 2*err: signed 13 bits
  - dx, dy: sign-extended to 12 bits
  - no overflow is possible within these widths.
- DRAW, each cycle:
  - drive horizontal_out/vertical_out = current point and write_enable_out = 1.
  - If the current point equals (x1, y1): go to DONE.
  - Otherwise, with e2 = 2*err:
    - if e2 >= dy: err += dy, x += sx
    - if e2 <= dx: err += dx, y += sy
    - both updates use the same pre-update err and may occur in the same cycle (diagonal step).
- Pixel count is exactly max(|dx|,|dy|) + 1, emitted on consecutive cycles, first pixel (x0,y0), last pixel (x1,y1).
- DONE:
  - write_enable_out = 0, ready_out = 1
  - outputs hold the last pixel
  - stays in DONE while enable_in = 1, so no redraw
  - enable_in = 0 returns to IDLE
  - a new line requires enable_in to drop and re-assert.
- Timing:
  - enable sampled at edge N: ready_out low after edge N; SETUP in cycle N+1; first pixel strobe after edge N+2.
  - ready_out rises on the edge after the last pixel is presented.
- Input changes while not in IDLE are ignored (endpoints are latched).
- Single point (x0 = x1, y0 = y1): exactly one pixel strobe, then DONE.

Test Plan:
- Reset then x0=10,y0=10,x1=0,y1=0, enable=1 until ready rises:
  - 11 strobes: (10,10),(9,9),...,(0,0)
  - ready_out 0 during draw, rises after (0,0)
  - enable dropped → IDLE.
- Horizontal (0,5)->(7,5): 8 strobes, x 0..7, y constant 5; then vertical (3,0)->(3,4): 5 strobes, y 0..4.
- Shallow line (0,0)->(5,2):
  - exactly 6 strobes, x strictly increasing by 1
  - y monotonic, ends (5,2)
  - matches software Bresenham golden model.
- Steep/negative line (1023,511)->(1020,0):
  - 512 strobes, y decrementing by 1, x monotonic non-increasing
  - no width overflow; matches golden model.
- Single point (4,4)->(4,4): exactly one strobe at (4,4); ready high after; holding enable high produces no further strobes.
- Assert reset_n_in low mid-line: outputs immediately return to reset values (ready 1, write_enable 0, coords 0); after release a fresh enable draws a full new line correctly.
